// File: rtl/wl_fb_pkg.sv
// ---------------------------------------------------------------------------
// wl_fb_pkg
// Shared types and width helpers for the ping-pong frame-store controller.
//   bank_st_t : per-bank occupancy state
//   wr_st_t   : capture (writer) FSM states
//   rd_st_t   : readout (reader) FSM states
//   PIPE_*    : layout of the {valid, sof, eof} read-pipe word
//   DROP_*    : dropped-frame counter width and saturation value
// ---------------------------------------------------------------------------
package wl_fb_pkg;

    typedef enum logic [1:0] {
        B_EMPTY,
        B_WRITING,
        B_FULL,
        B_READING
    } bank_st_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ACT,
        W_DROP
    } wr_st_t;

    typedef enum logic {
        R_IDLE,
        R_RUN
    } rd_st_t;

    localparam int unsigned PIPE_W   = 3;
    localparam int unsigned PIPE_VLD = 2;
    localparam int unsigned PIPE_SOF = 1;
    localparam int unsigned PIPE_EOF = 0;

    localparam int unsigned        DROP_W   = 16;
    localparam logic [DROP_W-1:0]  DROP_SAT = '1;

endpackage

// File: rtl/wl_fb_rd_pipe.sv
// ---------------------------------------------------------------------------
// wl_fb_rd_pipe
// RL-deep delay of the read-side {valid, sof, eof} flags so they line up
// with memory read data that appears RL cycles after the read enable.
//   clk, rst_b                  : clock, synchronous active-low reset
//   valid_in, sof_in, eof_in    : flags issued alongside the read address
//   valid_out, sof_out, eof_out : flags aligned with memory read data
//   busy                        : any stage holds a valid read
// ---------------------------------------------------------------------------
module wl_fb_rd_pipe
    import wl_fb_pkg::*;
#(
    parameter int unsigned RL = 2
) (
    input  logic clk,
    input  logic rst_b,
    input  logic valid_in,
    input  logic sof_in,
    input  logic eof_in,
    output logic valid_out,
    output logic sof_out,
    output logic eof_out,
    output logic busy
);

    logic [PIPE_W-1:0] stg [RL+1];

    assign stg[0] = {valid_in, sof_in, eof_in};

    for (genvar i = 0; i < RL; i++) begin : g_stage
        wl_regd #(
            .W (PIPE_W)
        ) u_regd (
            .clk   (clk),
            .rst_b (rst_b),
            .d     (stg[i]),
            .q     (stg[i+1])
        );
    end

    assign valid_out = stg[RL][PIPE_VLD];
    assign sof_out   = stg[RL][PIPE_SOF];
    assign eof_out   = stg[RL][PIPE_EOF];

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 1; i <= RL; i++) begin
            busy = busy | stg[i][PIPE_VLD];
        end
    end

endmodule

// File: rtl/wl_regd.sv
// ---------------------------------------------------------------------------
// wl_regd
// Generic W-bit register, synchronous active-low reset to zero.
//   clk   : clock
//   rst_b : synchronous active-low reset
//   d     : next value
//   q     : registered value
// ---------------------------------------------------------------------------
module wl_regd #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/wl_frame_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// wl_frame_pingpong_ctrl
// Ping-pong frame-store controller over one dual-port memory split into two
// banks (address MSB selects the bank). Frames qualified by vvalid/hvalid are
// captured into a free bank; FULL banks are streamed out in arrival order,
// with the output flags realigned to the memory read latency. Frames that
// arrive with no free bank are dropped and counted.
//   clk, rst_b        : clock, synchronous active-low reset
//   hvalid, vvalid    : line / frame qualifiers;  din : input pixel
//   mem_wea/addra/dina: write port {bank, offset}
//   mem_enb/addrb     : read port {bank, offset};  mem_doutb : read data
//   pix_valid/data/sof/eof : output pixel stream
//   drop_cnt          : saturating dropped-frame count
//   ovf               : sticky, a frame exceeded FRAME_PIX pixels
//   busy              : any bank occupied or reads still in flight
// ---------------------------------------------------------------------------
module wl_frame_pingpong_ctrl
    import wl_fb_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 21,
    parameter int unsigned FRAME_PIX = 2073600,
    parameter int unsigned RL        = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              hvalid,
    input  logic              vvalid,
    input  logic [DW-1:0]     din,
    output logic              mem_wea,
    output logic [AW:0]       mem_addra,
    output logic [DW-1:0]     mem_dina,
    output logic              mem_enb,
    output logic [AW:0]       mem_addrb,
    input  logic [DW-1:0]     mem_doutb,
    output logic              pix_valid,
    output logic [DW-1:0]     pix_data,
    output logic              pix_sof,
    output logic              pix_eof,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              ovf,
    output logic              busy
);

    localparam int unsigned   CW        = AW + 1;
    localparam logic [CW-1:0] FRAME_MAX = CW'(FRAME_PIX);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic vv_d;
    logic frame_start;
    logic frame_end;

    bank_st_t      bank_st     [2];
    bank_st_t      bank_st_nx  [2];
    logic [CW-1:0] bank_len    [2];
    logic [CW-1:0] bank_len_nx [2];
    logic          older_bank;
    logic          older_nx;

    wr_st_t        wr_st;
    wr_st_t        wr_st_nx;
    logic          wr_bank;
    logic          wr_bank_nx;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] wr_cnt_nx;

    rd_st_t        rd_st;
    rd_st_t        rd_st_nx;
    logic          rd_bank;
    logic          rd_bank_nx;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] rd_cnt_nx;
    logic          rd_last;

    logic [DROP_W-1:0] drop_nx;
    logic              ovf_nx;

    logic pipe_sof;
    logic pipe_eof;
    logic pipe_busy;

    assign frame_start = vvalid & ~vv_d;
    assign frame_end   = ~vvalid & vv_d;

    // Reader is evaluated before the writer in the same block so that a bank
    // released this cycle is already EMPTY when the writer picks a bank.
    always_comb begin
        bank_st_nx  = bank_st;
        bank_len_nx = bank_len;
        older_nx    = older_bank;
        wr_st_nx    = wr_st;
        wr_bank_nx  = wr_bank;
        wr_cnt_nx   = wr_cnt;
        rd_st_nx    = rd_st;
        rd_bank_nx  = rd_bank;
        rd_cnt_nx   = rd_cnt;
        drop_nx     = drop_cnt;
        ovf_nx      = ovf;
        mem_wea     = 1'b0;
        mem_addra   = '0;
        mem_dina    = '0;
        mem_enb     = 1'b0;
        mem_addrb   = '0;
        rd_last     = 1'b0;
        pipe_sof    = 1'b0;
        pipe_eof    = 1'b0;

        case (rd_st)
            R_IDLE: begin
                if (bank_st[0] == B_FULL || bank_st[1] == B_FULL) begin
                    if (bank_st[0] == B_FULL && bank_st[1] == B_FULL) begin
                        rd_bank_nx = older_bank;
                    end else begin
                        rd_bank_nx = (bank_st[1] == B_FULL);
                    end
                    bank_st_nx[rd_bank_nx] = B_READING;
                    rd_cnt_nx              = '0;
                    rd_st_nx               = R_RUN;
                end
            end
            R_RUN: begin
                mem_enb   = 1'b1;
                mem_addrb = {rd_bank, rd_cnt[AW-1:0]};
                rd_last   = (rd_cnt == bank_len[rd_bank] - CNT_ONE);
                pipe_sof  = (rd_cnt == '0);
                pipe_eof  = rd_last;
                if (rd_last) begin
                    bank_st_nx[rd_bank] = B_EMPTY;
                    rd_st_nx            = R_IDLE;
                end else begin
                    rd_cnt_nx = rd_cnt + CNT_ONE;
                end
            end
            default: rd_st_nx = R_IDLE;
        endcase

        case (wr_st)
            W_IDLE: begin
                if (frame_start) begin
                    if (bank_st_nx[0] == B_EMPTY) begin
                        wr_bank_nx    = 1'b0;
                        bank_st_nx[0] = B_WRITING;
                        wr_cnt_nx     = '0;
                        wr_st_nx      = W_ACT;
                    end else if (bank_st_nx[1] == B_EMPTY) begin
                        wr_bank_nx    = 1'b1;
                        bank_st_nx[1] = B_WRITING;
                        wr_cnt_nx     = '0;
                        wr_st_nx      = W_ACT;
                    end else begin
                        drop_nx  = (drop_cnt == DROP_SAT) ? drop_cnt
                                                          : drop_cnt + DROP_W'(1);
                        wr_st_nx = W_DROP;
                    end
                end
            end
            W_ACT: begin
                if (frame_end) begin
                    bank_len_nx[wr_bank] = wr_cnt;
                    if (wr_cnt == '0) begin
                        bank_st_nx[wr_bank] = B_EMPTY;
                    end else begin
                        bank_st_nx[wr_bank] = B_FULL;
                        // If the other bank is still waiting, it arrived first.
                        older_nx = (bank_st_nx[~wr_bank] == B_FULL) ? ~wr_bank
                                                                    : wr_bank;
                    end
                    wr_st_nx = W_IDLE;
                end else if (hvalid && vvalid) begin
                    if (wr_cnt < FRAME_MAX) begin
                        mem_wea   = 1'b1;
                        mem_addra = {wr_bank, wr_cnt[AW-1:0]};
                        mem_dina  = din;
                        wr_cnt_nx = wr_cnt + CNT_ONE;
                    end else begin
                        ovf_nx = 1'b1;
                    end
                end
            end
            W_DROP: begin
                if (frame_end) begin
                    wr_st_nx = W_IDLE;
                end
            end
            default: wr_st_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            vv_d        <= 1'b0;
            bank_st[0]  <= B_EMPTY;
            bank_st[1]  <= B_EMPTY;
            bank_len[0] <= '0;
            bank_len[1] <= '0;
            older_bank  <= 1'b0;
            wr_st       <= W_IDLE;
            wr_bank     <= 1'b0;
            wr_cnt      <= '0;
            rd_st       <= R_IDLE;
            rd_bank     <= 1'b0;
            rd_cnt      <= '0;
            drop_cnt    <= '0;
            ovf         <= 1'b0;
        end else begin
            vv_d       <= vvalid;
            bank_st    <= bank_st_nx;
            bank_len   <= bank_len_nx;
            older_bank <= older_nx;
            wr_st      <= wr_st_nx;
            wr_bank    <= wr_bank_nx;
            wr_cnt     <= wr_cnt_nx;
            rd_st      <= rd_st_nx;
            rd_bank    <= rd_bank_nx;
            rd_cnt     <= rd_cnt_nx;
            drop_cnt   <= drop_nx;
            ovf        <= ovf_nx;
        end
    end

    wl_fb_rd_pipe #(
        .RL (RL)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_b     (rst_b),
        .valid_in  (mem_enb),
        .sof_in    (pipe_sof),
        .eof_in    (pipe_eof),
        .valid_out (pix_valid),
        .sof_out   (pix_sof),
        .eof_out   (pix_eof),
        .busy      (pipe_busy)
    );

    assign pix_data = pix_valid ? mem_doutb : '0;
    assign busy     = (bank_st[0] != B_EMPTY) || (bank_st[1] != B_EMPTY) || pipe_busy;

endmodule

// File: tb/tb_wl_frame_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wl_frame_pingpong_ctrl
// Directed bench for wl_frame_pingpong_ctrl with a 2-cycle-latency memory
// model. Write-port and output-pixel activity is logged at the falling edge
// and compared against hand-built expected frame lists.
// ---------------------------------------------------------------------------
module tb_wl_frame_pingpong_ctrl;

    localparam int unsigned DW        = 8;
    localparam int unsigned AW        = 4;
    localparam int unsigned FRAME_PIX = 16;
    localparam int unsigned RL        = 2;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          hvalid;
    logic          vvalid;
    logic [DW-1:0] din;
    logic          mem_wea;
    logic [AW:0]   mem_addra;
    logic [DW-1:0] mem_dina;
    logic          mem_enb;
    logic [AW:0]   mem_addrb;
    logic [DW-1:0] mem_doutb = '0;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_sof;
    logic          pix_eof;
    logic [15:0]   drop_cnt;
    logic          ovf;
    logic          busy;

    always #5 clk = ~clk;

    wl_frame_pingpong_ctrl #(
        .DW        (DW),
        .AW        (AW),
        .FRAME_PIX (FRAME_PIX),
        .RL        (RL)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .hvalid    (hvalid),
        .vvalid    (vvalid),
        .din       (din),
        .mem_wea   (mem_wea),
        .mem_addra (mem_addra),
        .mem_dina  (mem_dina),
        .mem_enb   (mem_enb),
        .mem_addrb (mem_addrb),
        .mem_doutb (mem_doutb),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_eof   (pix_eof),
        .drop_cnt  (drop_cnt),
        .ovf       (ovf),
        .busy      (busy)
    );

    // Memory model: registered read plus output register (RL = 2). A read
    // slot without enable returns 0xEE so ungated output data is visible.
    logic [DW-1:0] mem [2**(AW+1)];
    logic [DW-1:0] rd_s1 = '0;
    initial for (int i = 0; i < 2**(AW+1); i++) mem[i] = '0;
    always @(posedge clk) begin
        if (mem_wea) mem[mem_addra] <= mem_dina;
        rd_s1     <= mem_enb ? mem[mem_addrb] : 8'hEE;
        mem_doutb <= rd_s1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Activity logs, only written here.
    logic [9:0]  out_q [$];
    int          out_cyc [$];
    logic [12:0] wr_q [$];
    int          gate_err = 0;
    int          coll_err = 0;
    always @(negedge clk) begin
        if (pix_valid) begin
            out_q.push_back({pix_sof, pix_eof, pix_data});
            out_cyc.push_back(cyc);
        end
        if (!pix_valid && pix_data != '0) gate_err++;
        if (mem_wea) wr_q.push_back({mem_addra, mem_dina});
        if (mem_wea && mem_enb && mem_addra[AW] == mem_addrb[AW]) coll_err++;
    end

    always @(posedge clk) begin
        if (cyc > 20000) begin
            $display("FAIL watchdog cyc=%0d limit=20000", cyc);
            $fatal(1);
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int w_base = 0;
    int o_base = 0;
    int fall_cyc = 0;
    logic [9:0]  exp_o [$];
    logic [12:0] exp_w [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start cycle (vvalid only), n pixel cycles, then gap blank cycles.
    task automatic send_frame(input int n, input logic [7:0] base, input int gap);
        tick();
        vvalid = 1'b1;
        hvalid = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            hvalid = 1'b1;
            din    = base + 8'(k);
        end
        for (int g = 0; g < gap; g++) begin
            tick();
            vvalid = 1'b0;
            hvalid = 1'b0;
            din    = '0;
            if (g == 0) fall_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic exp_writes(input logic bank, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) exp_w.push_back({bank, 4'(k), base + 8'(k)});
    endtask

    task automatic exp_pixels(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) exp_o.push_back({k == 0, k == n - 1, base + 8'(k)});
    endtask

    task automatic check_logs(input string name);
        chk({name, "_nwr"}, 32'(wr_q.size() - w_base), 32'(exp_w.size()));
        foreach (exp_w[i])
            if (w_base + i < wr_q.size())
                chk($sformatf("%s_wr%0d", name, i), 32'(wr_q[w_base + i]), 32'(exp_w[i]));
        chk({name, "_nout"}, 32'(out_q.size() - o_base), 32'(exp_o.size()));
        foreach (exp_o[i])
            if (o_base + i < out_q.size())
                chk($sformatf("%s_out%0d", name, i), 32'(out_q[o_base + i]), 32'(exp_o[i]));
        w_base = wr_q.size();
        o_base = out_q.size();
        exp_w.delete();
        exp_o.delete();
    endtask

    initial begin
        rst_b  = 1'b0;
        hvalid = 1'b0;
        vvalid = 1'b0;
        din    = '0;
        idle(3);
        @(negedge clk);
        chk("rst_busy",   32'(busy),      0);
        chk("rst_pv",     32'(pix_valid), 0);
        chk("rst_pdata",  32'(pix_data),  0);
        chk("rst_wea",    32'(mem_wea),   0);
        chk("rst_enb",    32'(mem_enb),   0);
        chk("rst_drop",   32'(drop_cnt),  0);
        chk("rst_ovf",    32'(ovf),       0);
        tick();
        rst_b = 1'b1;
        idle(2);
        w_base = wr_q.size();
        o_base = out_q.size();

        // T1: single 8-pixel frame. vvalid low in cycle f -> FULL at f+1,
        // R_RUN at f+2, first pixel out at f+4.
        send_frame(8, 8'h00, 1);
        idle(30);
        chk("t1_lat", (out_q.size() > o_base) ? 32'(out_cyc[o_base] - fall_cyc) : 32'hFFFF_FFFF, 4);
        exp_writes(1'b0, 8'h00, 8);
        exp_pixels(8'h00, 8);
        check_logs("t1");
        chk("t1_drop", 32'(drop_cnt), 0);
        chk("t1_busy", 32'(busy), 0);

        // T2: A(16) -> bank0, B(4) -> bank1 while A is read, C dropped.
        send_frame(16, 8'hA0, 1);
        send_frame(4,  8'hB0, 1);
        send_frame(16, 8'hC0, 1);
        idle(40);
        exp_writes(1'b0, 8'hA0, 16);
        exp_writes(1'b1, 8'hB0, 4);
        exp_pixels(8'hA0, 16);
        exp_pixels(8'hB0, 4);
        check_logs("t2");
        chk("t2_drop", 32'(drop_cnt), 1);
        chk("t2_ovf",  32'(ovf), 0);

        // T3: 20-pixel frame clipped to FRAME_PIX.
        send_frame(20, 8'h30, 1);
        idle(40);
        exp_writes(1'b0, 8'h30, 16);
        exp_pixels(8'h30, 16);
        check_logs("t3");
        chk("t3_ovf", 32'(ovf), 1);

        // T4: vvalid pulse with no pixels.
        send_frame(0, 8'h00, 1);
        @(negedge clk);
        chk("t4_busy_fall", 32'(busy), 1);
        idle(2);
        @(negedge clk);
        chk("t4_busy_after", 32'(busy), 0);
        idle(10);
        check_logs("t4");
        chk("t4_ovf_sticky", 32'(ovf), 1);
        chk("t4_drop", 32'(drop_cnt), 1);

        // T5: reset pulse during readout (outputs at f+4, f+5 before it).
        send_frame(8, 8'h50, 1);
        idle(5);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        @(negedge clk);
        chk("t5_pv",   32'(pix_valid), 0);
        chk("t5_enb",  32'(mem_enb),   0);
        chk("t5_busy", 32'(busy),      0);
        chk("t5_drop", 32'(drop_cnt),  0);
        chk("t5_ovf",  32'(ovf),       0);
        exp_writes(1'b0, 8'h50, 8);
        exp_o.push_back({1'b1, 1'b0, 8'h50});
        exp_o.push_back({1'b0, 1'b0, 8'h51});
        check_logs("t5a");
        send_frame(4, 8'h60, 1);
        idle(20);
        exp_writes(1'b0, 8'h60, 4);
        exp_pixels(8'h60, 4);
        check_logs("t5b");

        // T6: S starts in the exact cycle the reader releases bank1 while
        // bank0 holds R, so S must land in bank1 without a drop.
        send_frame(4, 8'h70, 1);
        send_frame(8, 8'h80, 1);
        send_frame(2, 8'h90, 5);
        send_frame(3, 8'hD0, 1);
        idle(40);
        exp_writes(1'b0, 8'h70, 4);
        exp_writes(1'b1, 8'h80, 8);
        exp_writes(1'b0, 8'h90, 2);
        exp_writes(1'b1, 8'hD0, 3);
        exp_pixels(8'h70, 4);
        exp_pixels(8'h80, 8);
        exp_pixels(8'h90, 2);
        exp_pixels(8'hD0, 3);
        check_logs("t6");
        chk("t6_drop", 32'(drop_cnt), 0);
        chk("t6_busy", 32'(busy), 0);

        chk("gate_err", 32'(gate_err), 0);
        chk("coll_err", 32'(coll_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
